mod_updown_counter: RTL and testbench
=====================================

Name: mod_updown_counter

Overview:
- Parametrised successor to the team's 3-bit clear/increment counter.
- Generalised to any width and any modulus, with up/down counting, a variable step, a synchronous load, and a selectable wrap or saturate mode.
- Outputs terminal-count flags and single-cycle overflow/underflow pulses.
- Used by FSM timers, pointer generators and event tallies across the design.

Parameters:
- WIDTH, 8: width of count and load_value in bits (≥2).
- MAX_VAL, 255: largest legal count; modulus is MAX_VAL+1. Legal range is 1 ≤ MAX_VAL ≤ 2^WIDTH−1.
- SATURATE, 0: 0 = wrap modulo MAX_VAL+1; 1 = clamp at 0 / MAX_VAL.
- STEP_W, 4: width of the step input in bits (1 ≤ STEP_W ≤ WIDTH).

Ports:
- clk, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous active-low reset.
- clear, input, 1: synchronous clear to 0; highest-priority command.
- load, input, 1: synchronous load of load_value.
- load_value, input, WIDTH: value to load.
- enable, input, 1: count-step qualifier.
- up, input, 1: direction; 1 = up, 0 = down.
- step, input, STEP_W: amount added or subtracted per enabled cycle.
- count, output, WIDTH: registered count value.
- at_max, output, 1: combinational, count == MAX_VAL.
- at_min, output, 1: combinational, count == 0.
- overflow, output, 1: registered one-cycle pulse on an upward pass or clamp past MAX_VAL.
- underflow, output, 1: registered one-cycle pulse on a downward pass or clamp past 0.

Behaviour:
- Reset (reset_n low, asynchronous, at any time, including mid-count):
  - count = 0, overflow = 0, underflow = 0.
  - Therefore at_min = 1 and at_max = 0.
  - Release is sampled at the next rising edge; no count update occurs on the edge coinciding with release-glitch timing.
- Command priority each rising edge: clear > load > enable > hold.
- clear: count ← 0; overflow and underflow ← 0. load, enable, up and step are ignored.
- load:
  - count ← min(load_value, MAX_VAL); out-of-range loads clamp to MAX_VAL.
  - overflow and underflow ← 0.
- enable with up = 1:
  - Let s = min(step, MAX_VAL) and t = count + s, computed at WIDTH+1 bits.
  - If t ≤ MAX_VAL: count ← t, no flag.
  - Else, wrap mode: count ← t − (MAX_VAL+1), overflow ← 1.
  - Else, saturate mode: count ← MAX_VAL, overflow ← 1. This includes count already at MAX_VAL with s > 0.
- enable with up = 0:
  - Same s as above.
  - If count ≥ s: count ← count − s, no flag.
  - Else, wrap mode: count ← count + (MAX_VAL+1) − s, underflow ← 1.
  - Else, saturate mode: count ← 0, underflow ← 1.
- Single-correction rule: because s is clamped to MAX_VAL, one conditional add or subtract of the modulus is always sufficient. No divider is permitted.
- step = 0 with enable: count unchanged, no flags.
- No command (hold), or an enable cycle without a boundary crossing: count unchanged, or stepped as above; overflow and underflow ← 0. Flags are pulses and never sticky.
- Flag timing: overflow and underflow are registered on the same edge that updates count. A flag is therefore visible during the cycle in which the new count is visible.
- count never leaves the range 0..MAX_VAL after reset under any input combination.
- Latency: 1 cycle from a sampled command to the updated count. at_max and at_min follow count combinationally with no added latency.
- Generic parameter check: WIDTH=3, MAX_VAL=7 with STEP_W=1 and SATURATE=0 reproduces the legacy counter's behaviour when up is tied to 1 and enable is used as increment.

Test Plan (WIDTH=4, MAX_VAL=9, STEP_W=3 unless noted):
- Assert reset_n low mid-count at count=6, asynchronously between edges -> count=0 immediately, overflow=0, at_min=1. After release with enable=1, up=1, step=1: count goes 1, 2, 3 on successive edges.
- SATURATE=0, count=8, up=1, step=3, one enable -> count=1, overflow=1 for exactly one cycle. Then down with step=2 -> count=9, underflow=1.
- SATURATE=1, count=8, up=1, step=3 -> count=9, overflow=1. A further enable -> count=9, overflow=1 again. Then up=0, step=7 from 9 -> 2, then 0 with underflow=1.
- load=1 with load_value=15 -> count=9 and at_max=1. load and clear in the same cycle -> count=0. load with enable in the same cycle -> load value wins.
- step=7 with MAX_VAL=5 (WIDTH=3, STEP_W=3), wrap mode, count=4, up -> s=5, count=3, overflow=1. step=0 with enable -> count unchanged, no flag.
- Randomized 10k cycles against a reference model, both modes -> count always ≤ MAX_VAL, and flags are never asserted on clear, load or hold cycles.

Source files
------------

// File: rtl/mod_updown_counter_if.sv
// Command and status bundle for mod_updown_counter.
// The master drives commands; the counter (slave) returns count, terminal flags and pulses.
interface mod_updown_counter_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  // Commands are level-sampled on every rising clk edge; there is no valid/ready
  // handshake. Priority is clear > load > enable > hold.
  logic              clear;
  logic              load;
  logic [WIDTH-1:0]  load_value;
  logic              enable;
  logic              up;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  count;
  logic              at_max;
  logic              at_min;
  logic              overflow;
  logic              underflow;

  modport master (
    output clear, load, load_value, enable, up, step,
    input  count, at_max, at_min, overflow, underflow
  );

  modport slave (
    input  clear, load, load_value, enable, up, step,
    output count, at_max, at_min, overflow, underflow
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Parametrised modulo/saturating up/down counter with variable step, synchronous
// load/clear, terminal-count flags and registered overflow/underflow pulses.
module mod_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 255,
  parameter int SATURATE = 0,
  parameter int STEP_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mod_updown_counter_if.slave   cnt_if
);

  localparam int EW = WIDTH + 1;
  localparam logic [WIDTH:0] MAX_EXT = EW'(MAX_VAL);
  localparam logic [WIDTH:0] MOD_EXT = EW'(MAX_VAL + 1);

  logic [WIDTH-1:0] count_q;
  logic             overflow_q;
  logic             underflow_q;

  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   s_clamp;
  logic [WIDTH:0]   sum_up;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH:0]   next_ext;
  logic             next_ov;
  logic             next_un;

  // The step is clamped to MAX_VAL so a single add/subtract of the modulus
  // always brings the result back into 0..MAX_VAL.
  always_comb begin
    count_ext = {1'b0, count_q};
    step_ext  = EW'(cnt_if.step);
    s_clamp   = (step_ext > MAX_EXT) ? MAX_EXT : step_ext;
    sum_up    = count_ext + s_clamp;
    load_ext  = {1'b0, cnt_if.load_value};
    next_ext  = count_ext;
    next_ov   = 1'b0;
    next_un   = 1'b0;

    if (cnt_if.clear) begin
      next_ext = '0;
    end else if (cnt_if.load) begin
      next_ext = (load_ext > MAX_EXT) ? MAX_EXT : load_ext;
    end else if (cnt_if.enable) begin
      if (cnt_if.up) begin
        if (sum_up > MAX_EXT) begin
          next_ov  = 1'b1;
          next_ext = (SATURATE != 0) ? MAX_EXT : (sum_up - MOD_EXT);
        end else begin
          next_ext = sum_up;
        end
      end else begin
        if (count_ext >= s_clamp) begin
          next_ext = count_ext - s_clamp;
        end else begin
          next_un  = 1'b1;
          next_ext = (SATURATE != 0) ? '0 : (count_ext + (MOD_EXT - s_clamp));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= WIDTH'(next_ext);
      overflow_q  <= next_ov;
      underflow_q <= next_un;
    end
  end

  assign cnt_if.count     = count_q;
  assign cnt_if.at_max    = (count_q == WIDTH'(MAX_VAL));
  assign cnt_if.at_min    = (count_q == '0);
  assign cnt_if.overflow  = overflow_q;
  assign cnt_if.underflow = underflow_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: three instances (wrap 0..9, saturate 0..9, wrap 0..5)
// driven in lockstep and checked against an integer reference model via a scoreboard.
module tb_mod_updown_counter;

  logic clk;
  logic reset_n;

  mod_updown_counter_if #(.WIDTH(4), .STEP_W(3)) ifc0 ();
  mod_updown_counter_if #(.WIDTH(4), .STEP_W(3)) ifc1 ();
  mod_updown_counter_if #(.WIDTH(3), .STEP_W(3)) ifc2 ();

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .STEP_W(3))
    u_wrap (.clk(clk), .reset_n(reset_n), .cnt_if(ifc0.slave));
  mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .STEP_W(3))
    u_sat (.clk(clk), .reset_n(reset_n), .cnt_if(ifc1.slave));
  mod_updown_counter #(.WIDTH(3), .MAX_VAL(5), .SATURATE(0), .STEP_W(3))
    u_small (.clk(clk), .reset_n(reset_n), .cnt_if(ifc2.slave));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- drive and observe arrays ----------------
  logic       d_clr [3];
  logic       d_ld  [3];
  logic [3:0] d_lv  [3];
  logic       d_en  [3];
  logic       d_up  [3];
  logic [2:0] d_st  [3];

  logic [3:0] o_cnt [3];
  logic       o_ov  [3];
  logic       o_un  [3];
  logic       o_max [3];
  logic       o_min [3];

  assign ifc0.clear = d_clr[0]; assign ifc0.load = d_ld[0]; assign ifc0.load_value = d_lv[0];
  assign ifc0.enable = d_en[0]; assign ifc0.up = d_up[0];   assign ifc0.step = d_st[0];
  assign ifc1.clear = d_clr[1]; assign ifc1.load = d_ld[1]; assign ifc1.load_value = d_lv[1];
  assign ifc1.enable = d_en[1]; assign ifc1.up = d_up[1];   assign ifc1.step = d_st[1];
  assign ifc2.clear = d_clr[2]; assign ifc2.load = d_ld[2]; assign ifc2.load_value = d_lv[2][2:0];
  assign ifc2.enable = d_en[2]; assign ifc2.up = d_up[2];   assign ifc2.step = d_st[2];

  assign o_cnt[0] = ifc0.count;         assign o_ov[0] = ifc0.overflow; assign o_un[0] = ifc0.underflow;
  assign o_cnt[1] = ifc1.count;         assign o_ov[1] = ifc1.overflow; assign o_un[1] = ifc1.underflow;
  assign o_cnt[2] = {1'b0, ifc2.count}; assign o_ov[2] = ifc2.overflow; assign o_un[2] = ifc2.underflow;
  assign o_max[0] = ifc0.at_max; assign o_min[0] = ifc0.at_min;
  assign o_max[1] = ifc1.at_max; assign o_min[1] = ifc1.at_min;
  assign o_max[2] = ifc2.at_max; assign o_min[2] = ifc2.at_min;

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];
  int          m_cnt [3];
  int          n_checks;
  int          n_pass;

  function automatic int max_of(input int idx);
    return (idx == 2) ? 5 : 9;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
  endtask

  // Reference model: advances m_cnt[idx] for the currently driven command.
  task automatic model_apply(input int idx, output logic ov, output logic un);
    int maxv, s, t, lv;
    bit sat;
    maxv = max_of(idx);
    sat  = (idx == 1);
    lv   = (idx == 2) ? int'(d_lv[idx][2:0]) : int'(d_lv[idx]);
    ov = 1'b0;
    un = 1'b0;
    if (d_clr[idx]) m_cnt[idx] = 0;
    else if (d_ld[idx]) m_cnt[idx] = (lv > maxv) ? maxv : lv;
    else if (d_en[idx]) begin
      s = (int'(d_st[idx]) > maxv) ? maxv : int'(d_st[idx]);
      if (d_up[idx]) begin
        t = m_cnt[idx] + s;
        if (t > maxv) begin
          ov = 1'b1;
          m_cnt[idx] = sat ? maxv : t - (maxv + 1);
        end else m_cnt[idx] = t;
      end else if (m_cnt[idx] >= s) begin
        m_cnt[idx] = m_cnt[idx] - s;
      end else begin
        un = 1'b1;
        m_cnt[idx] = sat ? 0 : m_cnt[idx] + maxv + 1 - s;
      end
    end
  endtask

  task automatic check_outputs(input int i, input logic [3:0] cnt, input logic ov, input logic un);
    check($sformatf("u%0d_count", i),     32'(o_cnt[i]), 32'(cnt));
    check($sformatf("u%0d_overflow", i),  32'(o_ov[i]),  32'(ov));
    check($sformatf("u%0d_underflow", i), 32'(o_un[i]),  32'(un));
    check($sformatf("u%0d_at_max", i),    32'(o_max[i]), 32'(int'(cnt) == max_of(i)));
    check($sformatf("u%0d_at_min", i),    32'(o_min[i]), 32'(cnt == 4'd0));
  endtask

  // Push expectations for the driven command, take the edge, pop and compare.
  task automatic step_cycle();
    logic [17:0] e;
    logic ov, un;
    e = '0;
    for (int i = 0; i < 3; i++) begin
      model_apply(i, ov, un);
      e[i*6 +: 6] = {ov, un, 4'(m_cnt[i])};
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    for (int i = 0; i < 3; i++) check_outputs(i, e[i*6 +: 4], e[i*6+5], e[i*6+4]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int idx, input logic clr, input logic ld, input logic [3:0] lv,
                       input logic en, input logic up, input logic [2:0] st);
    d_clr[idx] = clr; d_ld[idx] = ld; d_lv[idx] = lv;
    d_en[idx]  = en;  d_up[idx] = up; d_st[idx] = st;
  endtask

  task automatic drive_all(input logic clr, input logic ld, input logic [3:0] lv,
                           input logic en, input logic up, input logic [2:0] st);
    for (int i = 0; i < 3; i++) drive(i, clr, ld, lv, en, up, st);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    drive_all(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    #3;
    for (int i = 0; i < 3; i++) check_outputs(i, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reach count 6, then reset asynchronously between edges.
    drive_all(1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 3'd0);
    step_cycle();
    drive_all(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 3'd1);
    #3;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      check_outputs(i, 4'd0, 1'b0, 1'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step_cycle();

    // Boundary crossings: wrap and saturate from 8 with step 3; clamped step 7 on 0..5.
    drive(0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 3'd0);
    drive(1, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 3'd0);
    drive(2, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 3'd0);
    step_cycle();
    drive(0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 3'd3);
    drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 3'd3);
    drive(2, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 3'd7);
    step_cycle();
    drive(0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd2);
    drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 3'd3);
    drive(2, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 3'd0);
    step_cycle();
    drive(0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd7);
    drive(2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd5);
    repeat (2) step_cycle();

    // Load clamping and command priority.
    drive_all(1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 3'd0);
    step_cycle();
    drive_all(1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 3'd1);
    step_cycle();
    drive_all(1'b0, 1'b1, 4'd4, 1'b1, 1'b1, 3'd2);
    step_cycle();
    drive_all(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd2);
    step_cycle();

    // Randomised traffic covering every command mix in both modes.
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 3; i++) begin
        int r;
        r = $urandom_range(0, 15);
        drive(i, r == 0, (r == 1) || (r == 2), 4'($urandom_range(0, 15)),
              $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end
      step_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
